// File: rtl/cobi_scan_pkg.sv
// ---------------------------------------------------------------------------
// cobi_scan_pkg
// Shared types and width helpers for the COBI scanout reader.
//   scanState_e   : readout sequencer states
//   divCntWidth() : width of the strobe divider counter for a given CLK_DIV
//   bitCntWidth() : width of a counter that must reach N inclusive
//   chainWidth()  : bits captured per chain (chips * bits per chip)
// ---------------------------------------------------------------------------
package cobi_scan_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SAMP_HI = 3'd1,
      SAMP_LO = 3'd2,
      SH_LO   = 3'd3,
      SH_HI   = 3'd4,
      DONE    = 3'd5
   } scanState_e;

   // A divide-by-one divider still needs a one-bit register to stay legal
   function automatic int divCntWidth(input int clkDiv);
      return (clkDiv > 1) ? $clog2(clkDiv) : 1;
   endfunction

   function automatic int bitCntWidth(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int chainWidth(input int chips, input int bitsPerChip);
      return chips * bitsPerChip;
   endfunction

endpackage

// File: rtl/cobi_scan_shreg.sv
// ---------------------------------------------------------------------------
// cobi_scan_shreg
// One per chain: W-bit left-shifting capture register fed by the chain's
// serial DOUT. The first bit shifted in ends up at the MSB.
// Optional macro COBI_SCANOUT_PARITY_EN adds a running XOR of captured bits.
//   clk_i      : system clock
//   rstn_i     : synchronous active-low reset
//   shiftEn_i  : capture strobe (one per scanout clock rising edge)
//   serial_i   : chain serial data
//   word_o     : captured word
//   clear_i    : (parity build) clears the parity accumulator
//   parity_o   : (parity build) XOR of all bits captured since clear
// ---------------------------------------------------------------------------
module cobi_scan_shreg #(
   parameter int W = 64
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         shiftEn_i,
   input  logic         serial_i,
   output logic [W-1:0] word_o
`ifdef COBI_SCANOUT_PARITY_EN
   ,
   input  logic         clear_i,
   output logic         parity_o
`endif
);

   logic [W-1:0] word_q;

   // Shift left on each capture strobe; contents are held otherwise so the
   // last readout stays visible until the next one overwrites it.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         word_q <= '0;
      end else if (shiftEn_i) begin
         word_q <= {word_q[W-2:0], serial_i};
      end
   end

   assign word_o = word_q;

`ifdef COBI_SCANOUT_PARITY_EN
   logic parity_q;

   // Running parity of the captured stream, restarted with each readout
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         parity_q <= 1'b0;
      end else if (clear_i) begin
         parity_q <= 1'b0;
      end else if (shiftEn_i) begin
         parity_q <= parity_q ^ serial_i;
      end
   end

   assign parity_o = parity_q;
`endif

endmodule

// File: rtl/cobi_scanout_reader.sv
// ---------------------------------------------------------------------------
// cobi_scanout_reader
// Reads spin states out of the COBI chip network after an anneal: one
// sample-clock pulse, then N = NUM_CHIPS_PER_CHAIN*BITS_PER_CHIP scanout
// clock pulses, capturing each chain's DOUT into a parallel word that is
// offered on a valid/ready interface. Strobe half-periods are CLK_DIV cycles.
// Optional macro COBI_SCANOUT_PARITY_EN adds o_PARITY (per-chain XOR).
//   i_CLK, i_RSTN      : clock, synchronous active-low reset
//   i_START            : readout request (IDLE, or DONE with handshake)
//   o_BUSY             : high whenever not IDLE
//   o_SAMPLE_CLK       : network sample clock
//   o_SCANOUT_CLK      : network scanout clock
//   o_ALL_ROW_HI       : scan fill value, tied low
//   i_SCANOUT_DOUT64   : serial data, one bit per chain
//   o_DATA             : chain c at [W*(c+1)-1 : W*c]
//   o_VALID / i_READY  : output handshake
//   o_PARITY           : (parity build) per-chain parity of captured bits
// ---------------------------------------------------------------------------
module cobi_scanout_reader
   import cobi_scan_pkg::*;
#(
   parameter int NUM_CHAINS          = 4,
   parameter int NUM_CHIPS_PER_CHAIN = 1,
   parameter int BITS_PER_CHIP       = 64,
   parameter int CLK_DIV             = 2
) (
   input  logic                                                 i_CLK,
   input  logic                                                 i_RSTN,
   input  logic                                                 i_START,
   output logic                                                 o_BUSY,
   output logic                                                 o_SAMPLE_CLK,
   output logic                                                 o_SCANOUT_CLK,
   output logic                                                 o_ALL_ROW_HI,
   input  logic [NUM_CHAINS-1:0]                                i_SCANOUT_DOUT64,
   output logic [NUM_CHAINS*NUM_CHIPS_PER_CHAIN*BITS_PER_CHIP-1:0] o_DATA,
   output logic                                                 o_VALID,
   input  logic                                                 i_READY
`ifdef COBI_SCANOUT_PARITY_EN
   ,
   output logic [NUM_CHAINS-1:0]                                o_PARITY
`endif
);

   localparam int W     = chainWidth(NUM_CHIPS_PER_CHAIN, BITS_PER_CHIP);
   localparam int N     = W;
   localparam int DIV_W = divCntWidth(CLK_DIV);
   localparam int BIT_W = bitCntWidth(N);

   scanState_e       state_q, state_d;
   logic [DIV_W-1:0] divCnt_q, divCnt_d;
   logic [BIT_W-1:0] bitCnt_q, bitCnt_d;
   logic             sampleClk_q, scanClk_q, busy_q, valid_q;
   logic             divDone;
   logic             shiftEn;
   logic             handshake;

   assign divDone   = (divCnt_q == DIV_W'(CLK_DIV - 1));
   // The strobe outputs lag the state by one cycle, so the first SH_HI cycle
   // is exactly the edge on which o_SCANOUT_CLK goes 0->1.
   assign shiftEn   = (state_q == SH_HI) && !scanClk_q;
   // A transfer only counts once o_VALID is actually visible to the consumer
   assign handshake = valid_q && i_READY;

   // Next-state logic: sequencing, divider and saturating bit counter
   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitCnt_q;

      if (shiftEn && (bitCnt_q != BIT_W'(N))) begin
         bitCnt_d = bitCnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (i_START) begin
               state_d  = SAMP_HI;
               bitCnt_d = '0;
            end
         end
         SAMP_HI: if (divDone) state_d = SAMP_LO;
         SAMP_LO: if (divDone) state_d = SH_LO;
         SH_LO:   if (divDone) state_d = SH_HI;
         SH_HI: begin
            // bitCnt_d already includes a capture happening this cycle
            if (divDone) state_d = (bitCnt_d < BIT_W'(N)) ? SH_LO : DONE;
         end
         DONE: begin
            if (handshake) begin
               if (i_START) begin
                  state_d  = SAMP_HI;
                  bitCnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Divider restarts on every state change and idles outside timed states
      if ((state_d != state_q) || (state_q == IDLE) || (state_q == DONE)) begin
         divCnt_d = '0;
      end else begin
         divCnt_d = divCnt_q + 1'b1;
      end
   end

   // State, counters and registered network/handshake outputs
   always_ff @(posedge i_CLK) begin
      if (!i_RSTN) begin
         state_q     <= IDLE;
         divCnt_q    <= '0;
         bitCnt_q    <= '0;
         sampleClk_q <= 1'b0;
         scanClk_q   <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         divCnt_q    <= divCnt_d;
         bitCnt_q    <= bitCnt_d;
         sampleClk_q <= (state_q == SAMP_HI);
         scanClk_q   <= (state_q == SH_HI);
         busy_q      <= (state_d != IDLE);
         valid_q     <= (state_q == DONE) && !handshake;
      end
   end

`ifdef COBI_SCANOUT_PARITY_EN
   logic parityClear;
   assign parityClear = (state_d == SAMP_HI) && (state_q != SAMP_HI);
`endif

   // One capture register per chain
   for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
      cobi_scan_shreg #(
         .W(W)
      ) u_shreg (
         .clk_i     (i_CLK),
         .rstn_i    (i_RSTN),
         .shiftEn_i (shiftEn),
         .serial_i  (i_SCANOUT_DOUT64[c]),
         .word_o    (o_DATA[W*c +: W])
`ifdef COBI_SCANOUT_PARITY_EN
         ,
         .clear_i   (parityClear),
         .parity_o  (o_PARITY[c])
`endif
      );
   end

   assign o_BUSY        = busy_q;
   assign o_SAMPLE_CLK  = sampleClk_q;
   assign o_SCANOUT_CLK = scanClk_q;
   assign o_VALID       = valid_q;
   assign o_ALL_ROW_HI  = 1'b0;

endmodule
